// File: rtl/bm_dag3_pkg.sv
// bm_dag3_pkg: shared state encoding and shift-register constants for the dag3 stimulus generator
package bm_dag3_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [7:0] TAPS8 = 8'b1011_1000;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;
endpackage

// File: rtl/bm_dag3_lfsr_misr.sv
// bm_dag3_lfsr_misr: 8-bit tapped left-shift register with load and XOR data input
module bm_dag3_lfsr_misr
    import bm_dag3_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic [7:0] data,
    output logic [7:0] value
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) value <= RESET_VALUE;
        else if (load) value <= load_value;
        else if (enable) value <= {value[6:0], ^(value & TAPS8)} ^ data;
endmodule

// File: rtl/bm_dag3_stim_gen.sv
// bm_dag3_stim_gen: drives LFSR operand vectors into dag3 and compacts its responses into a MISR signature
module bm_dag3_stim_gen
    import bm_dag3_pkg::*;
#(
    parameter int BITS = 2,
    parameter int NUM_VECTORS = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [7:0]      seed,
    output logic [BITS-1:0] first,
    output logic [BITS-1:0] sceond,
    output logic            third,
    output logic            fourth,
    input  logic [BITS-1:0] resp0,
    input  logic            resp1,
    output logic            busy,
    output logic            done,
    output logic [7:0]      vec_count,
    output logic [7:0]      signature
);
    state_t     state;
    logic [3:0] drain_count;
    logic [7:0] lfsr;
    logic       run;
    logic       accept;

    assign run    = state == RUN;
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = run || state == DRAIN;
    assign done   = state == DONE;
    assign first  = run ? lfsr[BITS-1:0] : '0;
    assign sceond = run ? lfsr[2*BITS-1:BITS] : '0;
    assign third  = run & lfsr[2*BITS];
    assign fourth = run & lfsr[2*BITS+1];

    bm_dag3_lfsr_misr #(.RESET_VALUE(DEFAULT_SEED)) u_lfsr (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (run),
        .load       (accept),
        .load_value (seed == 8'h00 ? DEFAULT_SEED : seed),
        .data       (8'h00),
        .value      (lfsr)
    );

    bm_dag3_lfsr_misr #(.RESET_VALUE(8'h00)) u_misr (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (busy),
        .load       (accept),
        .load_value (8'h00),
        .data       (8'({resp1, resp0})),
        .value      (signature)
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state       <= IDLE;
            vec_count   <= 8'd0;
            drain_count <= 4'd0;
        end else if (accept) begin
            state     <= RUN;
            vec_count <= 8'd0;
        end else if (run) begin
            vec_count   <= vec_count < 8'(NUM_VECTORS) ? vec_count + 8'd1 : vec_count;
            drain_count <= 4'd0;
            if (vec_count == 8'(NUM_VECTORS - 1)) state <= DRAIN_CYCLES == 0 ? DONE : DRAIN;
        end else if (state == DRAIN) begin
            drain_count <= drain_count + 4'd1;
            if (drain_count == 4'(DRAIN_CYCLES - 1)) state <= DONE;
        end
endmodule

// File: tb/tb_bm_dag3_stim_gen.sv
// tb_bm_dag3_stim_gen: directed passes with random responses checked against a behavioural signature model
module tb_bm_dag3_stim_gen;
    localparam int N = 16;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [1:0] first, sceond;
    logic       third, fourth;
    logic [1:0] resp0 = 2'b00;
    logic       resp1 = 1'b0;
    logic       busy, done;
    logic [7:0] vec_count, signature;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] seed1_tab [5] = '{6'b01_00_0_0, 6'b10_00_0_0, 6'b00_01_0_0, 6'b00_10_0_0, 6'b01_00_1_0};

    always #5 clock = ~clock;

    bm_dag3_stim_gen #(.BITS(2), .NUM_VECTORS(N), .DRAIN_CYCLES(D)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .seed      (seed),
        .first     (first),
        .sceond    (sceond),
        .third     (third),
        .fourth    (fourth),
        .resp0     (resp0),
        .resp1     (resp1),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .signature (signature)
    );

    function automatic logic [7:0] step(input logic [7:0] x);
        return ((x << 1) & 8'hFF) | 8'(x[7] ^ x[5] ^ x[4] ^ x[3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode: 0 random responses, 1 quiet, 2 pulse on last drain cycle, 3 pulse one cycle earlier
    task automatic run_pass(input logic [7:0] s, input int mode, input bit busy_start, input bit hold);
        logic [7:0] l, m;
        logic [1:0] r0;
        logic       r1;
        seed  = s;
        start = 1'b1;
        tick();
        start = hold;
        l = (s == 8'h00) ? 8'h01 : s;
        m = 8'h00;
        for (int c = 0; c < N + D; c++) begin
            check("busy", 32'(busy), 1);
            check("done_low", 32'(done), 0);
            check("vec_count", 32'(vec_count), c < N ? c : N);
            check("operands", 32'({first, sceond, third, fourth}), c < N ? 32'({l[1:0], l[3:2], l[4], l[5]}) : 0);
            if (s <= 8'h01 && c < 5) check("seed1_vector", 32'({first, sceond, third, fourth}), 32'(seed1_tab[c]));
            if (s == 8'h08 && c == 0) check("seed8_vector", 32'({first, sceond, third, fourth}), 32'(6'b00_10_0_0));
            r0 = mode == 0 ? 2'($urandom) : ((mode == 2 && c == N + D - 1) || (mode == 3 && c == N + D - 2)) ? 2'b01 : 2'b00;
            r1 = mode == 0 ? 1'($urandom) : 1'b0;
            resp0 = r0;
            resp1 = r1;
            m = step(m) ^ {5'b0, r1, r0};
            if (c < N) l = step(l);
            if (busy_start) start = (c == 3);
            tick();
        end
        resp0 = 2'b00;
        resp1 = 1'b0;
        start = hold;
        check("done_high", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        check("vec_final", 32'(vec_count), N);
        check("operands_done", 32'({first, sceond, third, fourth}), 0);
        check("signature_model", 32'(signature), 32'(m));
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_vec", 32'(vec_count), 0);
        check("rst_sig", 32'(signature), 0);
        check("rst_ops", 32'({first, sceond, third, fourth}), 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 0);
        run_pass(8'h01, 1, 1'b0, 1'b0);
        check("quiet_sig", 32'(signature), 32'h00);
        run_pass(8'h00, 3, 1'b0, 1'b0);
        check("early_pulse_sig", 32'(signature), 32'h02);
        run_pass(8'h5A, 2, 1'b0, 1'b0);
        check("last_pulse_sig", 32'(signature), 32'h01);
        run_pass(8'($urandom), 0, 1'b1, 1'b0);
        run_pass(8'h08, 0, 1'b0, 1'b1);
        run_pass(8'h08, 0, 1'b0, 1'b0);
        tick();
        check("done_hold", 32'(done), 1);
        check("done_hold_vec", 32'(vec_count), N);
        seed  = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        resp0 = 2'b11;
        resp1 = 1'b1;
        repeat (5) tick();
        check("midrun_vec", 32'(vec_count), 5);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_vec", 32'(vec_count), 0);
        check("abort_sig", 32'(signature), 0);
        check("abort_ops", 32'({first, sceond, third, fourth}), 0);
        resp0 = 2'b00;
        resp1 = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_abort_idle", 32'({busy, done}), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
